// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one synchronous RAM port between fetch and data requesters
module mem_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             if_req,
  input  logic [31:0]      if_addr,
  input  logic             if_flush,
  output logic             if_ack,
  output logic             if_rvalid,
  output logic [31:0]      if_rdata,
  input  logic             mem_req,
  input  logic [3:0]       mem_wen,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  output logic             mem_ack,
  output logic             mem_rvalid,
  output logic [31:0]      mem_rdata,
  output logic             ram_en,
  output logic [3:0]       ram_wen,
  output logic [31:0]      ram_addr,
  output logic [31:0]      ram_wdata,
  input  logic [31:0]      ram_rdata,
  output logic [CNT_W-1:0] conflict_cnt
);
  typedef enum logic [1:0] {IDLE, RET_IF, RET_MEM} state_t;
  state_t           state_q, state_d;
  logic             last_mem_q, last_mem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             if_elig, gnt_if, gnt_mem;
  // Return-tracking state, round-robin pointer and saturating contention counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      last_mem_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_mem_q <= last_mem_d;
      cnt_q      <= cnt_d;
    end
  end
  // Arbitration, RAM port drive, data returns and next-state; grants are suppressed during reset
  always_comb begin
    if_elig    = if_req & ~if_flush;
    gnt_mem    = resetn & mem_req & (~if_elig | ~last_mem_q);
    gnt_if     = resetn & if_elig & ~gnt_mem;
    if_ack     = gnt_if;
    mem_ack    = gnt_mem;
    ram_en     = gnt_if | gnt_mem;
    ram_wen    = gnt_mem ? mem_wen : 4'h0;
    ram_addr   = gnt_mem ? mem_addr : gnt_if ? if_addr : 32'h0;
    ram_wdata  = gnt_mem ? mem_wdata : 32'h0;
    if_rvalid  = resetn & (state_q == RET_IF) & ~if_flush;
    mem_rvalid = resetn & (state_q == RET_MEM);
    if_rdata   = if_rvalid ? ram_rdata : 32'h0;
    mem_rdata  = mem_rvalid ? ram_rdata : 32'h0;
    state_d    = gnt_if ? RET_IF : (gnt_mem && mem_wen == 4'h0) ? RET_MEM : IDLE;
    last_mem_d = (gnt_if | gnt_mem) ? gnt_mem : last_mem_q;
    cnt_d      = (if_elig && mem_req && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  assign conflict_cnt = cnt_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  logic        clk = 0, resetn = 0;
  logic        if_req = 0, if_flush = 0, mem_req = 0;
  logic [31:0] if_addr = 0, mem_addr = 0, mem_wdata = 0, ram_rdata = 0;
  logic [3:0]  mem_wen = 0;
  logic        if_ack, if_rvalid, mem_ack, mem_rvalid, ram_en;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
  logic [3:0]  ram_wen;
  logic [15:0] conflict_cnt;
  logic        s_if_ack, s_if_rvalid, s_mem_ack, s_mem_rvalid, s_ram_en;
  logic [31:0] s_if_rdata, s_mem_rdata, s_ram_addr, s_ram_wdata;
  logic [3:0]  s_ram_wen, s_conflict_cnt;
  int checks = 0, errors = 0;
  int owed[$];
  bit last_mem;
  int contentions;
  always #5 clk = ~clk;
  mem_arbiter dut (
    .clk(clk), .resetn(resetn), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ack(if_ack), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .mem_req(mem_req),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .ram_en(ram_en), .ram_wen(ram_wen),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .conflict_cnt(conflict_cnt)
  );
  mem_arbiter #(.CNT_W(4)) dut4 (
    .clk(clk), .resetn(resetn), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ack(s_if_ack), .if_rvalid(s_if_rvalid), .if_rdata(s_if_rdata), .mem_req(mem_req),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(s_mem_ack),
    .mem_rvalid(s_mem_rvalid), .mem_rdata(s_mem_rdata), .ram_en(s_ram_en), .ram_wen(s_ram_wen),
    .ram_addr(s_ram_addr), .ram_wdata(s_ram_wdata), .ram_rdata(ram_rdata), .conflict_cnt(s_conflict_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    owed.delete();
    last_mem = 0;
    contentions = 0;
  endtask
  task automatic all_zero(input string tag);
    chk({tag, "_acks"}, {30'h0, if_ack, mem_ack}, 32'h0);
    chk({tag, "_rvalid"}, {30'h0, if_rvalid, mem_rvalid}, 32'h0);
    chk({tag, "_rdata"}, if_rdata | mem_rdata, 32'h0);
    chk({tag, "_ram"}, {31'h0, ram_en} | {28'h0, ram_wen} | ram_addr | ram_wdata, 32'h0);
    chk({tag, "_cnt"}, {16'h0, conflict_cnt}, 32'h0);
  endtask
  // Compare every output against what the transaction model predicts for the current inputs
  task automatic settle();
    bit ie, gm, gi, irv, mrv;
    @(negedge clk);
    ie = if_req && !if_flush;
    gm = mem_req && (!ie || !last_mem);
    gi = ie && !gm;
    irv = owed.size() > 0 && owed[0] == 1 && !if_flush;
    mrv = owed.size() > 0 && owed[0] == 2;
    chk("if_ack", {31'h0, if_ack}, {31'h0, gi});
    chk("mem_ack", {31'h0, mem_ack}, {31'h0, gm});
    chk("ram_en", {31'h0, ram_en}, {31'h0, gi | gm});
    chk("ram_addr", ram_addr, gm ? mem_addr : gi ? if_addr : 32'h0);
    chk("ram_wen", {28'h0, ram_wen}, gm ? {28'h0, mem_wen} : 32'h0);
    chk("ram_wdata", ram_wdata, gm ? mem_wdata : 32'h0);
    chk("if_rvalid", {31'h0, if_rvalid}, {31'h0, irv});
    chk("mem_rvalid", {31'h0, mem_rvalid}, {31'h0, mrv});
    chk("if_rdata", if_rdata, irv ? ram_rdata : 32'h0);
    chk("mem_rdata", mem_rdata, mrv ? ram_rdata : 32'h0);
    chk("cnt16", {16'h0, conflict_cnt}, contentions > 65535 ? 32'hFFFF : 32'(contentions));
    chk("cnt4", {28'h0, s_conflict_cnt}, contentions > 15 ? 32'd15 : 32'(contentions));
  endtask
  // Advance the model by one clock: reads owe a return next cycle, writes owe nothing
  task automatic tick();
    bit ie, gm, gi;
    ie = if_req && !if_flush;
    gm = mem_req && (!ie || !last_mem);
    gi = ie && !gm;
    @(posedge clk);
    owed.delete();
    if (gi) owed.push_back(1);
    if (gm && mem_wen == 0) owed.push_back(2);
    if (gi || gm) last_mem = gm;
    if (ie && mem_req) contentions++;
    #1;
  endtask
  initial begin
    model_reset();
    if_req = 1; mem_req = 1; if_addr = 32'h10; mem_addr = 32'h20;
    #3 all_zero("reset");
    if_req = 0; mem_req = 0;
    @(negedge clk) resetn = 1;
    @(posedge clk); #1;
    settle();
    chk("no_rvalid_after_reset", {30'h0, if_rvalid, mem_rvalid}, 32'h0);
    tick();
    if_req = 1; mem_req = 1; mem_wen = 0; if_addr = 32'h40; mem_addr = 32'h80;
    for (int i = 0; i < 20; i++) begin
      settle();
      if (i < 4) chk("rr_mem_first", {31'h0, mem_ack}, {31'h0, i % 2 == 0});
      if (i == 4) chk("cnt_after4", {16'h0, conflict_cnt}, 32'd4);
      tick();
    end
    if_req = 0; mem_req = 0;
    settle();
    chk("cnt4_sat", {28'h0, s_conflict_cnt}, 32'd15);
    chk("cnt16_20", {16'h0, conflict_cnt}, 32'd20);
    tick();
    settle(); tick();
    if_req = 1; if_addr = 32'h34;
    settle();
    chk("fetch_ack", {31'h0, if_ack}, 32'h1);
    chk("fetch_addr", ram_addr, 32'h34);
    tick();
    if_req = 0; ram_rdata = 32'h3C010000;
    settle();
    chk("fetch_rvalid", {31'h0, if_rvalid}, 32'h1);
    chk("fetch_rdata", if_rdata, 32'h3C010000);
    tick();
    mem_req = 1; mem_wen = 4'hF; mem_addr = 32'h100; mem_wdata = 32'hDEADBEEF;
    settle();
    chk("wr_wen", {28'h0, ram_wen}, 32'hF);
    chk("wr_addr", ram_addr, 32'h100);
    chk("wr_wdata", ram_wdata, 32'hDEADBEEF);
    chk("wr_ack", {31'h0, mem_ack}, 32'h1);
    tick();
    mem_req = 0; mem_wen = 0;
    settle();
    chk("wr_no_rvalid", {31'h0, mem_rvalid}, 32'h0);
    tick();
    if_req = 1; if_addr = 32'h200;
    settle();
    chk("fl_grant", {31'h0, if_ack}, 32'h1);
    tick();
    if_flush = 1;
    settle();
    chk("fl_rvalid", {31'h0, if_rvalid}, 32'h0);
    chk("fl_ack", {31'h0, if_ack}, 32'h0);
    tick();
    if_flush = 0; if_req = 0;
    for (int i = 0; i < 400; i++) begin
      if_req = 1'($urandom); if_flush = ($urandom_range(0, 7) == 0);
      if_addr = $urandom; mem_req = 1'($urandom);
      mem_wen = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      mem_addr = $urandom; mem_wdata = $urandom; ram_rdata = $urandom;
      settle(); tick();
    end
    if_req = 0; if_flush = 0; mem_req = 1; mem_wen = 0; mem_addr = 32'h300;
    settle(); tick();
    mem_req = 0;
    #2 resetn = 0;
    model_reset();
    #1 chk("ret_mem_held", {31'h0, mem_rvalid}, 32'h0);
    all_zero("midreset");
    @(negedge clk) resetn = 1;
    @(posedge clk); #1;
    settle();
    chk("post_reset_no_mrv", {31'h0, mem_rvalid}, 32'h0);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
